crtc_timing: RTL and testbench

CRTC_TIMING -- requirements
Module: crtc_timing

---
 rtl/crtc_pkg.sv | 26 ++
 rtl/crtc_pulse.sv | 43 ++++
 rtl/crtc_timing.sv | 171 +++++++++++++++++
 tb/tb_crtc_timing.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crtc_pkg
//  Description : Shared types and constants for the CRTC timing generator:
//                vertical FSM state encoding, default vsync width and the
//                hsync width decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package crtc_pkg;

  // Vertical sequencer states: normal character rows, then extra scan lines
  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_ADJUST = 1'b1
  } vstate_t;

  // Default vertical sync width in scan lines
  localparam int VSYNC_LINES_DEFAULT = 16;

  // R3[3:0] encodes 1..15 directly; a value of 0 selects a 16-character pulse
  function automatic logic [4:0] hsync_len(input logic [3:0] width);
    return (width == 4'd0) ? 5'd16 : {1'b0, width};
  endfunction

endpackage
`default_nettype wire

// File: rtl/crtc_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : crtc_pulse
//  Description : Sync pulse stretcher. A start (sampled on an advance
//                enable) raises the output, which then stays high for
//                'width' advances in total. A start while already active
//                restarts the count.
//  Revision    : 1.0  initial release
// ============================================================================
module crtc_pulse #(
  parameter int CNT_W = 5
) (
  input  logic             clk16,
  input  logic             res_b,
  input  logic             advance,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  output logic             active
);

  logic [CNT_W-1:0] remain;

  // Load the width on start, then count down once per advance until expired
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      active <= 1'b0;
      remain <= '0;
    end else if (advance) begin
      if (start) begin
        active <= 1'b1;
        remain <= width - CNT_W'(1);
      end else if (active) begin
        if (remain == '0) begin
          active <= 1'b0;
        end else begin
          remain <= remain - CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/crtc_timing.sv
`default_nettype none
// ============================================================================
//  Module      : crtc_timing
//  Description : 6545-style CRT controller timing core. Horizontal character
//                counter, scan-line / row counters with a vertical-adjust
//                phase, memory-address generation and sync pulse timing.
//                All outputs are registered on the character-clock enable and
//                describe the character that was just counted.
//  Revision    : 1.0  initial release
// ============================================================================
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int VSYNC_LINES = VSYNC_LINES_DEFAULT
) (
  input  logic        clk16,
  input  logic        res_b,
  input  logic        char_en,
  input  logic [7:0]  h_total,
  input  logic [7:0]  h_displayed,
  input  logic [7:0]  h_sync_pos,
  input  logic [3:0]  sync_width,
  input  logic [6:0]  v_total,
  input  logic [4:0]  v_adjust,
  input  logic [6:0]  v_displayed,
  input  logic [6:0]  v_sync_pos,
  input  logic [4:0]  max_scan,
  input  logic [13:0] start_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [13:0] ma,
  output logic [4:0]  ra
);

  // Counter state
  logic [7:0]  h_cnt;
  logic [4:0]  ra_cnt;
  logic [6:0]  row;
  logic [4:0]  adj_cnt;
  vstate_t     state;
  logic [13:0] ma_row;
  logic        first_char;

  // Next-state values
  logic [7:0]  h_cnt_nxt;
  logic [4:0]  ra_nxt;
  logic [6:0]  row_nxt;
  logic [4:0]  adj_nxt;
  vstate_t     state_nxt;
  logic [13:0] ma_row_nxt;

  logic        eol;
  logic        eor;
  logic        eof;
  logic [13:0] row_base;
  logic        hs_start;
  logic        vs_start;
  logic        de_nxt;
  logic [13:0] ma_nxt;

  // Next-state decode for the horizontal, scan-line, row and frame counters
  always_comb begin
    // Until the first character after reset, the row base comes straight
    // from start_addr so that the very first character is already correct.
    row_base   = first_char ? start_addr : ma_row;
    eol        = (h_cnt >= h_total);
    eor        = eol && (state == ST_ACTIVE) && (ra_cnt >= max_scan);
    eof        = 1'b0;
    h_cnt_nxt  = eol ? 8'd0 : h_cnt + 8'd1;
    ra_nxt     = ra_cnt;
    row_nxt    = row;
    adj_nxt    = adj_cnt;
    state_nxt  = state;
    ma_row_nxt = row_base;

    if (eol) begin
      if (state == ST_ACTIVE) begin
        if (eor) begin
          row_nxt = row + 7'd1;
          ra_nxt  = 5'd0;
          if (row >= v_total) begin
            if (v_adjust != 5'd0) begin
              state_nxt = ST_ADJUST;
              adj_nxt   = 5'd0;
            end else begin
              eof = 1'b1;
            end
          end else begin
            ma_row_nxt = row_base + {6'd0, h_displayed};
          end
        end else begin
          ra_nxt = ra_cnt + 5'd1;
        end
      end else begin
        if (adj_cnt == v_adjust - 5'd1) begin
          eof = 1'b1;
        end else begin
          adj_nxt = adj_cnt + 5'd1;
          ra_nxt  = ra_cnt + 5'd1;
        end
      end
    end

    if (eof) begin
      row_nxt    = 7'd0;
      ra_nxt     = 5'd0;
      ma_row_nxt = start_addr;
      state_nxt  = ST_ACTIVE;
    end

    hs_start = (h_cnt == h_sync_pos);
    vs_start = eol && (state_nxt == ST_ACTIVE) && (row_nxt == v_sync_pos) && (ra_nxt == 5'd0);
    de_nxt   = (h_displayed != 8'd0) && (v_displayed != 7'd0) &&
               (h_cnt < h_displayed) && (row < v_displayed) && (state == ST_ACTIVE);
    ma_nxt   = row_base + {6'd0, h_cnt};
  end

  // Vertical FSM, counters and registered de/ma/ra, advancing on char_en only
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      h_cnt      <= 8'd0;
      ra_cnt     <= 5'd0;
      row        <= 7'd0;
      adj_cnt    <= 5'd0;
      state      <= ST_ACTIVE;
      ma_row     <= 14'd0;
      first_char <= 1'b1;
      de         <= 1'b0;
      ma         <= 14'd0;
      ra         <= 5'd0;
    end else if (char_en) begin
      h_cnt      <= h_cnt_nxt;
      ra_cnt     <= ra_nxt;
      row        <= row_nxt;
      adj_cnt    <= adj_nxt;
      state      <= state_nxt;
      ma_row     <= ma_row_nxt;
      first_char <= 1'b0;
      de         <= de_nxt;
      ma         <= ma_nxt;
      ra         <= ra_cnt;
    end
  end

  // Horizontal sync: counted in characters, free to run across end-of-line
  crtc_pulse #(
    .CNT_W (5)
  ) u_hsync (
    .clk16   (clk16),
    .res_b   (res_b),
    .advance (char_en),
    .start   (hs_start),
    .width   (hsync_len(sync_width)),
    .active  (hsync)
  );

  // Vertical sync: counted in scan lines, free to run across end-of-frame
  crtc_pulse #(
    .CNT_W (5)
  ) u_vsync (
    .clk16   (clk16),
    .res_b   (res_b),
    .advance (char_en && eol),
    .start   (vs_start),
    .width   (5'(VSYNC_LINES)),
    .active  (vsync)
  );

endmodule
`default_nettype wire

// File: tb/tb_crtc_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crtc_timing
//  Description : Self-checking bench for crtc_timing. A behavioural model
//                predicts every output per clock; predictions are queued as
//                stimulus is applied and compared after each edge. Directed
//                measurements check line/frame/pulse geometry against
//                fixed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crtc_timing;

  localparam int VS          = 16;
  localparam int FRAME_LIMIT = 40000;
  localparam int LINE_LIMIT  = 400;

  logic        clk16 = 1'b0;
  logic        res_b;
  logic        char_en;
  logic [7:0]  h_total, h_displayed, h_sync_pos;
  logic [3:0]  sync_width;
  logic [6:0]  v_total, v_displayed, v_sync_pos;
  logic [4:0]  v_adjust, max_scan;
  logic [13:0] start_addr;
  logic        hsync, vsync, de;
  logic [13:0] ma;
  logic [4:0]  ra;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [13:0] ma;
    logic [4:0]  ra;
  } out_t;

  out_t exp_q[$];
  out_t e_cur;
  int   checks   = 0;
  int   failures = 0;
  int   gap      = 0;

  // Model state
  logic [7:0]  m_h;
  logic [4:0]  m_ra, m_adj;
  logic [6:0]  m_row;
  logic [13:0] m_marow;
  bit          m_adjm, m_first;
  int          m_hs, m_vs;

  crtc_timing #(.VSYNC_LINES(VS)) dut (
    .clk16       (clk16),
    .res_b       (res_b),
    .char_en     (char_en),
    .h_total     (h_total),
    .h_displayed (h_displayed),
    .h_sync_pos  (h_sync_pos),
    .sync_width  (sync_width),
    .v_total     (v_total),
    .v_adjust    (v_adjust),
    .v_displayed (v_displayed),
    .v_sync_pos  (v_sync_pos),
    .max_scan    (max_scan),
    .start_addr  (start_addr),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .ma          (ma),
    .ra          (ra)
  );

  always #5 clk16 = ~clk16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 8'd0; m_ra = 5'd0; m_adj = 5'd0; m_row = 7'd0; m_marow = 14'd0;
    m_adjm = 1'b0; m_first = 1'b1; m_hs = 0; m_vs = 0;
    e_cur = '0;
  endtask

  // One counted character: outputs describe the character at the current position
  task automatic model_char();
    logic [13:0] base;
    bit          frame_end;
    base        = m_first ? start_addr : m_marow;
    e_cur.de    = (m_h < h_displayed) && (m_row < v_displayed) && !m_adjm;
    e_cur.ma    = base + 14'(m_h);
    e_cur.ra    = m_ra;
    if (m_h == h_sync_pos) m_hs = (sync_width == 4'd0) ? 16 : int'(sync_width);
    else if (m_hs > 0) m_hs--;
    e_cur.hsync = (m_hs > 0);
    m_first = 1'b0;
    m_marow = base;
    if (m_h < h_total) begin
      m_h++;
    end else begin
      m_h = 8'd0;
      frame_end = 1'b0;
      if (m_adjm) begin
        if (m_adj == 5'(v_adjust - 5'd1)) frame_end = 1'b1;
        else begin m_adj++; m_ra++; end
      end else if (m_ra >= max_scan) begin
        if (m_row >= v_total) begin
          if (v_adjust == 5'd0) frame_end = 1'b1;
          else begin m_adjm = 1'b1; m_adj = 5'd0; m_ra = 5'd0; m_row++; end
        end else begin
          m_row++; m_ra = 5'd0; m_marow = m_marow + 14'(h_displayed);
        end
      end else begin
        m_ra++;
      end
      if (frame_end) begin
        m_row = 7'd0; m_ra = 5'd0; m_marow = start_addr; m_adjm = 1'b0;
      end
      if (!m_adjm && m_row == v_sync_pos && m_ra == 5'd0) m_vs = VS;
      else if (m_vs > 0) m_vs--;
    end
    e_cur.vsync = (m_vs > 0);
  endtask

  // One clk16 cycle: queue the prediction, clock, then compare the DUT
  task automatic cycle(input bit en);
    out_t want, got;
    char_en = en;
    if (en && res_b) model_char();
    exp_q.push_back(e_cur);
    @(posedge clk16);
    #1;
    want = exp_q.pop_front();
    got  = {hsync, vsync, de, ma, ra};
    if (failures < 40) check("outputs", 32'(got), 32'(want));
    char_en = 1'b0;
  endtask

  task automatic step();
    repeat (gap) cycle(1'b0);
    cycle(1'b1);
  endtask

  task automatic apply_reset();
    char_en = 1'b0;
    res_b   = 1'b0;
    model_reset();
    cycle(1'b0);
    cycle(1'b0);
    res_b = 1'b1;
  endtask

  task automatic measure_hsync(output int width, output int period, output logic [13:0] ma_rise);
    int n;
    width = -1; period = -1; ma_rise = 14'h0; n = 0;
    while (hsync && n < LINE_LIMIT) begin step(); n++; end
    while (!hsync && n < LINE_LIMIT) begin step(); n++; end
    if (hsync) begin
      ma_rise = ma; width = 0; period = 0;
      while (hsync && n < LINE_LIMIT) begin step(); width++; period++; n++; end
      while (!hsync && n < LINE_LIMIT) begin step(); period++; n++; end
    end
  endtask

  task automatic measure_frame(output int lines, output int de_chars, output int vs_lines);
    int   n;
    logic ph, pv;
    lines = -1; de_chars = -1; vs_lines = -1; n = 0;
    while (vsync && n < FRAME_LIMIT) begin step(); n++; end
    while (!vsync && n < FRAME_LIMIT) begin step(); n++; end
    if (vsync) begin
      lines = 0; de_chars = 0; vs_lines = 0; ph = hsync; pv = vsync;
      while (n < FRAME_LIMIT) begin
        step(); n++;
        if (hsync && !ph) begin
          lines++;
          if (vsync) vs_lines++;
        end
        if (de) de_chars++;
        if (vsync && !pv) break;
        ph = hsync; pv = vsync;
      end
    end
  endtask

  initial begin
    int          w, p, lines5, lines0, dec, vsl, n;
    logic [13:0] mr;

    char_en = 1'b0; res_b = 1'b0;
    h_total = 8'h31; h_displayed = 8'h28; h_sync_pos = 8'h29; sync_width = 4'hF;
    v_total = 7'h28; v_adjust = 5'd5; v_displayed = 7'h19; v_sync_pos = 7'h21;
    max_scan = 5'd7; start_addr = 14'h0000;

    // Reset state
    apply_reset();
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_de",    32'(de),    32'd0);
    check("rst_ma",    32'(ma),    32'd0);
    check("rst_ra",    32'(ra),    32'd0);

    // PET timing with a character every 16 clocks
    gap = 15;
    measure_hsync(w, p, mr);
    check("pet_hsync_width", 32'(w), 32'd15);
    check("pet_chars_per_line", 32'(p), 32'd50);
    check("pet_hsync_start_ma", 32'(mr), 32'h29);

    // Whole frames, one character per clock
    gap = 0;
    measure_frame(lines5, dec, vsl);
    check("pet_lines_per_frame", 32'(lines5), 32'd333);
    check("pet_de_chars", 32'(dec), 32'd8000);
    check("pet_vsync_lines", 32'(vsl), 32'd16);
    v_adjust = 5'd0;
    measure_frame(lines0, dec, vsl);
    check("r5_0_lines_per_frame", 32'(lines0), 32'd328);
    check("r5_frame_delta", 32'(lines5 - lines0), 32'd5);

    // Reset in the middle of vsync with hsync also high
    n = 0;
    while (!hsync && n < 100) begin step(); n++; end
    check("pre_rst_vsync", 32'(vsync), 32'd1);
    check("pre_rst_hsync", 32'(hsync), 32'd1);
    #2;
    res_b = 1'b0;
    #1;
    check("async_rst_hsync", 32'(hsync), 32'd0);
    check("async_rst_vsync", 32'(vsync), 32'd0);
    check("async_rst_de",    32'(de),    32'd0);
    check("async_rst_ma",    32'(ma),    32'd0);
    model_reset();
    v_adjust   = 5'd5;
    start_addr = 14'h1234;
    cycle(1'b0);
    cycle(1'b0);
    res_b = 1'b1;
    step();
    check("post_rst_first_ma", 32'(ma), 32'h1234);
    check("post_rst_first_de", 32'(de), 32'd1);

    // Memory address wrap at the top of the 14-bit space
    start_addr = 14'h3FF0;
    apply_reset();
    for (int i = 0; i < 401; i++) begin
      step();
      if (i == 0)   check("wrap_first_ma", 32'(ma), 32'h3FF0);
      if (i == 15)  check("wrap_top_ma",   32'(ma), 32'h3FFF);
      if (i == 16)  check("wrap_zero_ma",  32'(ma), 32'h0000);
      if (i == 400) begin
        check("wrap_row1_ma", 32'(ma), 32'h0018);
        check("wrap_row1_ra", 32'(ra), 32'd0);
      end
    end

    // Lowering R0 below the current horizontal position
    start_addr = 14'h0000;
    apply_reset();
    repeat (32) step();
    h_total = 8'h10;
    step();
    check("r0_drop_last_ma", 32'(ma), 32'h20);
    step();
    check("r0_drop_wrap_ma", 32'(ma), 32'h0000);
    check("r0_drop_wrap_ra", 32'(ra), 32'd1);
    repeat (40) step();
    h_total = 8'h31;

    // 16-character hsync, then hsync straddling end-of-line
    sync_width = 4'h0;
    measure_hsync(w, p, mr);
    check("hsync_width_16", 32'(w), 32'd16);
    sync_width = 4'hF;
    h_sync_pos = 8'h31;
    measure_hsync(w, p, mr);
    check("hsync_eol_width", 32'(w), 32'd15);
    check("hsync_eol_period", 32'(p), 32'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
